// File: rtl/hms_display_formatter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hms_pkg
// Description : Shared field layout, constants, state type and BCD saturation
//               helper for the HMS display formatter.
// Revision    : 1.0 - initial release
// ============================================================================
package hms_pkg;

    localparam int HRS_LSB = 13;
    localparam int HRS_W   = 7;
    localparam int MIN_LSB = 6;
    localparam int MIN_W   = 6;
    localparam int SEC_LSB = 0;
    localparam int SEC_W   = 6;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam logic MODE_MMSS = 1'b0;
    localparam logic MODE_HHMM = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {overflow, tens, units}; any nonzero hundreds digit pins the pair at 99.
    function automatic logic [8:0] bcd_sat(input logic [11:0] bcd);
        if (bcd[11:8] != 4'd0) begin
            return {1'b1, 8'h99};
        end
        return {1'b0, bcd[7:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hms_display_formatter_if.sv
`default_nettype none
// ============================================================================
// Module      : hms_display_formatter_if
// Description : Time input and 4-digit display output bundle between the
//               timing block (master) and the display formatter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface hms_display_formatter_if;

    logic [19:0] hms_time;
    logic        sec_pulse;
    logic        half_sec_pulse;
    logic        mode;
    logic [15:0] digits_bcd;
    logic        digits_valid;
    logic        colon;
    logic        busy;
    logic        overflow;

    modport master (
        output hms_time, sec_pulse, half_sec_pulse, mode,
        input  digits_bcd, digits_valid, colon, busy, overflow
    );

    modport slave (
        input  hms_time, sec_pulse, half_sec_pulse, mode,
        output digits_bcd, digits_valid, colon, busy, overflow
    );

endinterface
`default_nettype wire

// File: rtl/hms_display_formatter_bcd_dd7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_dd7
// Description : Sequential 7-bit binary to 3-digit BCD converter, one
//               shift-add-3 iteration per step.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_dd7 #(
    parameter int CONV_STEPS = 7
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        load,
    input  wire logic        step,
    input  wire logic [6:0]  bin_in,
    output logic      [11:0] bcd,
    output logic             done
);

    localparam int c_cnt_w = $clog2(CONV_STEPS + 1);

    logic [6:0]         r_bin;
    logic [11:0]        r_bcd;
    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         w_adj;

    // The hundreds digit never exceeds 1 for a 7-bit input, so it needs no add-3.
    for (genvar i = 0; i < 2; i++) begin : g_adj
        assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? (r_bcd[4*i +: 4] + 4'd3)
                                                           : r_bcd[4*i +: 4];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_bin <= bin_in;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (step) begin
            r_bcd <= {r_bcd[10:8], w_adj, r_bin[6]};
            r_bin <= {r_bin[5:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bcd  = r_bcd;
    assign done = (r_cnt == c_cnt_w'(CONV_STEPS));

endmodule
`default_nettype wire

// File: rtl/hms_display_formatter.sv
`default_nettype none
// ============================================================================
// Module      : hms_display_formatter
// Description : Converts MM:SS or HH:MM from the packed time word into four
//               BCD display digits with a blinking colon.
// Revision    : 1.0 - initial release
// ============================================================================
module hms_display_formatter
    import hms_pkg::*;
#(
    parameter bit BLANK_LEADING_ZERO = 1'b0,
    parameter int CONV_STEPS         = 7
) (
    input  wire logic             clock,
    input  wire logic             reset,
    hms_display_formatter_if.slave bus
);

    localparam int c_iter_w = $clog2(CONV_STEPS);

    state_t              r_state;
    logic                r_pending;
    logic                r_cap_mode;
    logic                r_prev_mode;
    logic [c_iter_w-1:0] r_iter;
    logic                r_busy;
    logic                r_valid;
    logic                r_colon;
    logic                r_ovf;
    logic [15:0]         r_digits;

    logic [6:0]  w_hrs, w_min, w_sec, w_up_bin, w_lo_bin;
    logic [11:0] w_up_bcd, w_lo_bcd;
    logic [8:0]  w_up_sat, w_lo_sat;
    logic [3:0]  w_up_tens;
    logic        w_up_done, w_lo_done;
    logic        w_req, w_mode_edge, w_load, w_step;

    assign w_hrs = bus.hms_time[HRS_LSB +: HRS_W];
    assign w_min = {{(7 - MIN_W){1'b0}}, bus.hms_time[MIN_LSB +: MIN_W]};
    assign w_sec = {{(7 - SEC_W){1'b0}}, bus.hms_time[SEC_LSB +: SEC_W]};

    assign w_up_bin = (bus.mode == MODE_HHMM) ? w_hrs : w_min;
    assign w_lo_bin = (bus.mode == MODE_HHMM) ? w_min : w_sec;

    assign w_req       = bus.sec_pulse | (bus.mode != r_cap_mode) | r_pending;
    assign w_mode_edge = (bus.mode != r_prev_mode);
    assign w_load      = (r_state == IDLE) && w_req;
    assign w_step      = (r_state == CONV);

    bcd_dd7 #(.CONV_STEPS(CONV_STEPS)) u_dd_upper (
        .clock  (clock),
        .reset  (reset),
        .load   (w_load),
        .step   (w_step),
        .bin_in (w_up_bin),
        .bcd    (w_up_bcd),
        .done   (w_up_done)
    );

    bcd_dd7 #(.CONV_STEPS(CONV_STEPS)) u_dd_lower (
        .clock  (clock),
        .reset  (reset),
        .load   (w_load),
        .step   (w_step),
        .bin_in (w_lo_bin),
        .bcd    (w_lo_bcd),
        .done   (w_lo_done)
    );

    assign w_up_sat  = bcd_sat(w_up_bcd);
    assign w_lo_sat  = bcd_sat(w_lo_bcd);
    assign w_up_tens = (BLANK_LEADING_ZERO && (w_up_sat[7:4] == 4'd0)) ? BCD_BLANK
                                                                        : w_up_sat[7:4];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pending   <= 1'b1;
            r_cap_mode  <= MODE_MMSS;
            r_prev_mode <= MODE_MMSS;
            r_iter      <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_colon     <= 1'b0;
            r_ovf       <= 1'b0;
            r_digits    <= '0;
        end else begin
            r_valid     <= 1'b0;
            r_prev_mode <= bus.mode;

            // A freshly changed mode shows a steady colon, overriding the blink.
            if (w_mode_edge) begin
                r_colon <= 1'b1;
            end else if (bus.half_sec_pulse) begin
                r_colon <= ~r_colon;
            end

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_cap_mode <= bus.mode;
                        r_pending  <= 1'b0;
                        r_iter     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    if (w_req) begin
                        r_pending <= 1'b1;
                    end
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == c_iter_w'(CONV_STEPS - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (w_req) begin
                        r_pending <= 1'b1;
                    end
                    r_digits <= {w_up_tens, w_up_sat[3:0], w_lo_sat[7:0]};
                    r_ovf    <= w_up_sat[8] | w_lo_sat[8];
                    r_valid  <= w_up_done & w_lo_done;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.digits_bcd   = r_digits;
    assign bus.digits_valid = r_valid;
    assign bus.colon        = r_colon;
    assign bus.busy         = r_busy;
    assign bus.overflow     = r_ovf;

endmodule
`default_nettype wire
